// File: rtl/cpu_jtag_debug_host_sequencer.sv
// cpu_jtag_debug_host_sequencer: drives one SETUP/SHIFT/UPDATE/RTI debug transaction on a generated TCK and returns captured tdo bits
module cpu_jtag_debug_host_sequencer #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  input  logic                abort,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic                jtag_tck,
  output logic                jtag_ena,
  output logic [IR_WIDTH-1:0] jtag_ir_in,
  output logic                jtag_tdi,
  input  logic                jtag_tdo,
  output logic                jtag_shift,
  output logic                jtag_state_sdr,
  output logic                jtag_update,
  output logic                jtag_state_udr,
  output logic                jtag_rti
);
  localparam int DW = TCK_DIV > 1 ? $clog2(TCK_DIV) : 1;
  localparam int BW = $clog2(DR_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, UPDATE, RTI, DONE} state_t;
  state_t              state;
  logic [DW-1:0]       div;
  logic [BW-1:0]       bits;
  logic [DR_WIDTH-1:0] sreg;
  logic                run, tick, rise, fall;
  assign run       = state != IDLE && state != DONE;
  assign tick      = run && div == DW'(TCK_DIV - 1);
  assign rise      = tick && !jtag_tck;
  assign fall      = tick && jtag_tck;
  assign cmd_ready = state == IDLE && !rsp_valid;
  assign jtag_tdi  = jtag_ena & sreg[0];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      div            <= '0;
      bits           <= '0;
      sreg           <= '0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      busy           <= 1'b0;
      jtag_tck       <= 1'b0;
      jtag_ena       <= 1'b0;
      jtag_ir_in     <= '0;
      jtag_shift     <= 1'b0;
      jtag_state_sdr <= 1'b0;
      jtag_update    <= 1'b0;
      jtag_state_udr <= 1'b0;
      jtag_rti       <= 1'b0;
    end else if (run && abort) begin
      state          <= IDLE;
      div            <= '0;
      busy           <= 1'b0;
      jtag_tck       <= 1'b0;
      jtag_ena       <= 1'b0;
      jtag_shift     <= 1'b0;
      jtag_state_sdr <= 1'b0;
      jtag_update    <= 1'b0;
      jtag_state_udr <= 1'b0;
      jtag_rti       <= 1'b0;
    end else begin
      if (run) begin
        div <= tick ? '0 : div + DW'(1);
        if (tick) jtag_tck <= ~jtag_tck;
      end
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          state      <= SETUP;
          jtag_ir_in <= cmd_ir;
          sreg       <= cmd_data;
          bits       <= '0;
          div        <= '0;
          jtag_tck   <= 1'b0;
          jtag_ena   <= 1'b1;
          busy       <= 1'b1;
        end
        SETUP: if (fall) begin
          state          <= SHIFT;
          jtag_shift     <= 1'b1;
          jtag_state_sdr <= 1'b1;
        end
        SHIFT: begin
          if (rise) begin
            sreg <= {jtag_tdo, sreg[DR_WIDTH-1:1]};
            bits <= bits + BW'(1);
          end
          if (fall && bits == BW'(DR_WIDTH)) begin
            state          <= UPDATE;
            jtag_shift     <= 1'b0;
            jtag_state_sdr <= 1'b0;
            jtag_update    <= 1'b1;
            jtag_state_udr <= 1'b1;
          end
        end
        UPDATE: if (fall) begin
          state          <= RTI;
          jtag_update    <= 1'b0;
          jtag_state_udr <= 1'b0;
          jtag_rti       <= 1'b1;
        end
        RTI: if (fall) begin
          state    <= DONE;
          jtag_rti <= 1'b0;
          jtag_ena <= 1'b0;
        end
        DONE: if (!rsp_valid) begin
          rsp_valid <= 1'b1;
          rsp_data  <= sreg;
        end else if (rsp_ready) begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_jtag_debug_host_sequencer.sv
// tb_cpu_jtag_debug_host_sequencer: directed scoreboard bench with a loopback instance (TCK_DIV=1) and a tdo-high instance (TCK_DIV=2)
module tb_cpu_jtag_debug_host_sequencer;
  logic clk = 1'b0, reset = 1'b1, sel = 1'b0;
  logic cmd_valid = 1'b0, abort = 1'b0, rsp_ready = 1'b0;
  logic [1:0] cmd_ir = '0, cur_ir = '0;
  logic [37:0] cmd_data = '0, last_a = '0;
  logic a_cmd_ready, a_rsp_valid, a_busy, a_tck, a_ena, a_tdi, a_shift, a_sdr, a_upd, a_udr, a_rti;
  logic b_cmd_ready, b_rsp_valid, b_busy, b_tck, b_ena, b_tdi, b_shift, b_sdr, b_upd, b_udr, b_rti;
  logic [1:0] a_ir, b_ir;
  logic [37:0] a_rsp_data, b_rsp_data;
  logic m_cmd_ready, m_rsp_valid, m_busy, m_tck, m_ena, m_tdi, m_shift, m_sdr, m_upd, m_udr, m_rti;
  logic [1:0] m_ir;
  logic [37:0] m_rsp_data;
  int errors = 0, checks = 0;
  logic [37:0] exp_q[$];
  int lat_q[$];

  always #5 clk = ~clk;

  cpu_jtag_debug_host_sequencer #(.TCK_DIV(1)) u_a (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid & ~sel), .cmd_ready(a_cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .abort(abort & ~sel), .rsp_valid(a_rsp_valid),
    .rsp_ready(rsp_ready & ~sel), .rsp_data(a_rsp_data), .busy(a_busy), .jtag_tck(a_tck),
    .jtag_ena(a_ena), .jtag_ir_in(a_ir), .jtag_tdi(a_tdi), .jtag_tdo(a_tdi),
    .jtag_shift(a_shift), .jtag_state_sdr(a_sdr), .jtag_update(a_upd),
    .jtag_state_udr(a_udr), .jtag_rti(a_rti));

  cpu_jtag_debug_host_sequencer #(.TCK_DIV(2)) u_b (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid & sel), .cmd_ready(b_cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .abort(abort & sel), .rsp_valid(b_rsp_valid),
    .rsp_ready(rsp_ready & sel), .rsp_data(b_rsp_data), .busy(b_busy), .jtag_tck(b_tck),
    .jtag_ena(b_ena), .jtag_ir_in(b_ir), .jtag_tdi(b_tdi), .jtag_tdo(1'b1),
    .jtag_shift(b_shift), .jtag_state_sdr(b_sdr), .jtag_update(b_upd),
    .jtag_state_udr(b_udr), .jtag_rti(b_rti));

  assign m_cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
  assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
  assign m_busy      = sel ? b_busy : a_busy;
  assign m_tck       = sel ? b_tck : a_tck;
  assign m_ena       = sel ? b_ena : a_ena;
  assign m_tdi       = sel ? b_tdi : a_tdi;
  assign m_shift     = sel ? b_shift : a_shift;
  assign m_sdr       = sel ? b_sdr : a_sdr;
  assign m_upd       = sel ? b_upd : a_upd;
  assign m_udr       = sel ? b_udr : a_udr;
  assign m_rti       = sel ? b_rti : a_rti;
  assign m_ir        = sel ? b_ir : a_ir;
  assign m_rsp_data  = sel ? b_rsp_data : a_rsp_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_tck"}, m_tck, 0);
    chk({tag, "_ena"}, m_ena, 0);
    chk({tag, "_tdi"}, m_tdi, 0);
    chk({tag, "_shift"}, {m_shift, m_sdr}, 0);
    chk({tag, "_update"}, {m_upd, m_udr}, 0);
    chk({tag, "_rti"}, m_rti, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_rsp_valid"}, m_rsp_valid, 0);
  endtask

  // Drives one accepted command; returns at the negedge right after the accept edge.
  task automatic send(input logic [1:0] ir, input logic [37:0] d, input logic [37:0] exp, input int lat, input bit push);
    @(negedge clk);
    chk("cmd_ready_before_accept", m_cmd_ready, 1);
    cmd_ir = ir;
    cmd_data = d;
    cmd_valid = 1'b1;
    cur_ir = ir;
    if (push) begin
      exp_q.push_back(exp);
      lat_q.push_back(lat);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_accept", m_busy, 1);
  endtask

  task automatic wait_rsp(input int tdiv, input int poke_at, input int hold);
    int n = 0, shifts = 0, upd = 0, rti_c = 0, irbad = 0, first_rise = -1, period = -1, lat;
    logic pt = 1'b0, pu = 1'b0;
    logic [37:0] exp_d, held;
    exp_d = exp_q.pop_front();
    lat = lat_q.pop_front();
    while (!m_rsp_valid && n < lat + 20) begin
      if (m_tck && !pt) begin
        if (m_shift) shifts++;
        if (first_rise < 0) first_rise = n;
        else if (period < 0) period = n - first_rise;
      end
      if (m_upd && !pu) upd++;
      if (m_rti) rti_c++;
      if (m_ir !== cur_ir) irbad++;
      pt = m_tck;
      pu = m_upd;
      if (n == poke_at) begin
        cmd_valid = 1'b1;
        cmd_data = ~cmd_data;
        cmd_ir = ~cmd_ir;
      end else cmd_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    cmd_valid = 1'b0;
    chk("rsp_latency", n, lat);
    chk("rsp_data", m_rsp_data, exp_d);
    chk("shift_tck_periods", shifts, 38);
    chk("update_pulses", upd, 1);
    chk("rti_cycles", rti_c, 2 * tdiv);
    chk("tck_period", period, 2 * tdiv);
    chk("ir_held", irbad, 0);
    chk("ena_low_in_done", m_ena, 0);
    held = m_rsp_data;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = (i == 3);
      cmd_data = ~cmd_data;
      @(negedge clk);
      chk("bp_rsp_valid", m_rsp_valid, 1);
      chk("bp_rsp_data", m_rsp_data, held);
      chk("bp_cmd_ready", m_cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", m_rsp_valid, 0);
    chk("hs_busy", m_busy, 0);
    chk("hs_cmd_ready", m_cmd_ready, 1);
    if (!sel) last_a = exp_d;
  endtask

  initial begin
    #3;
    chk_quiet("reset_async");
    chk("reset_rsp_data", m_rsp_data, 0);
    chk("reset_ir", m_ir, 0);
    @(negedge clk);
    reset = 1'b0;
    send(2'b01, 38'h2A_5A5A_A5A5, 38'h2A_5A5A_A5A5, 83, 1'b1);
    wait_rsp(1, -1, 0);
    send(2'b10, 38'h15_1234_5678, 38'h15_1234_5678, 83, 1'b1);
    wait_rsp(1, 20, 0);
    sel = 1'b1;
    send(2'b11, 38'h0, 38'h3F_FFFF_FFFF, 165, 1'b1);
    wait_rsp(2, -1, 10);
    sel = 1'b0;
    send(2'b01, 38'h0F_0F0F_0F0F, 38'h0, 0, 1'b0);
    repeat (20) @(negedge clk);
    chk("abort_pre_shift", m_shift, 1);
    chk("abort_pre_tck", m_tck, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_quiet("abort");
    chk("abort_cmd_ready", m_cmd_ready, 1);
    chk("abort_rsp_data", m_rsp_data, last_a);
    repeat (3) @(negedge clk);
    chk("abort_no_rsp", m_rsp_valid, 0);
    send(2'b10, 38'h0A_BCDE_F012, 38'h0A_BCDE_F012, 83, 1'b1);
    wait_rsp(1, -1, 0);
    send(2'b01, 38'h3C_3C3C_3C3C, 38'h0, 0, 1'b0);
    repeat (30) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_quiet("reset_mid_shift");
    chk("reset_mid_rsp_data", m_rsp_data, 0);
    @(negedge clk);
    reset = 1'b0;
    send(2'b10, 38'h33_3333_3333, 38'h33_3333_3333, 83, 1'b1);
    wait_rsp(1, -1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cpu_jtag_debug_host_sequencer.md
Name: cpu_jtag_debug_host_sequencer

Overview:
- Host-side driver for the CPU JTAG debug module's TAP-facing ports (ena, ir_in, tdi, shift, update, jtag_state_sdr, jtag_state_udr, rti, raw_tck, tdo).
- Accepts one debug command at a time: a 2-bit instruction plus a 38-bit data register value.
- Runs a full SETUP/SHIFT/UPDATE/RTI sequence on a generated TCK and returns the 38 bits captured from tdo.
- Used for on-chip self-test and simulation of the debug path without an external JTAG cable.

Parameters:
- DR_WIDTH, 38, data register length in bits (matches jdo width).
- IR_WIDTH, 2, instruction width (matches ir_in).
- TCK_DIV, 1, clk cycles per TCK half-period; legal values are 1 or greater.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_ir  in  IR_WIDTH  instruction to present on jtag_ir_in.
- cmd_data  in  DR_WIDTH  value to shift out on tdi, LSB first.
- abort  in  1  synchronous cancel of the in-flight command.
- rsp_valid  out  1  captured data available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DR_WIDTH  bits captured from tdo, LSB first.
- busy  out  1  high from command accept until response handshake.
- jtag_tck  out  1  generated TCK (drives raw_tck).
- jtag_ena  out  1  virtual-JTAG enable.
- jtag_ir_in  out  IR_WIDTH  instruction register value.
- jtag_tdi  out  1  serial data toward the debug module.
- jtag_tdo  in  1  serial data from the debug module.
- jtag_shift  out  1  shift phase.
- jtag_state_sdr  out  1  Shift-DR state.
- jtag_update  out  1  update phase.
- jtag_state_udr  out  1  Update-DR state.
- jtag_rti  out  1  Run-Test/Idle state.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - All outputs go to 0; rsp_data and the shift register go to 0.
  - jtag_tck goes low and the TCK divider clears.
- TCK generation:
  - Runs only outside IDLE/DONE. Period is 2*TCK_DIV clk cycles: low for TCK_DIV cycles, then high for TCK_DIV cycles.
  - Each state starts at the beginning of a low phase.
  - Rise tick = the clk edge on which jtag_tck goes 0->1. Fall tick = the clk edge on which it goes 1->0.
  - jtag_tck idles low.
- cmd_ready = (state==IDLE) && !rsp_valid. cmd_valid is ignored while cmd_ready is low.
- FSM states: IDLE, SETUP, SHIFT, UPDATE, RTI, DONE.
- IDLE -> SETUP on cmd_valid && cmd_ready:
  - Latch cmd_ir into jtag_ir_in.
  - Load cmd_data into the shift register.
  - Set busy=1.
- SETUP (1 TCK period):
  - jtag_ena=1.
  - jtag_tdi = sreg[0] from the first SETUP cycle onward.
- SHIFT (exactly DR_WIDTH TCK periods):
  - jtag_shift=1, jtag_state_sdr=1, jtag_tdi = sreg[0].
  - On each rise tick: sreg <= {jtag_tdo, sreg[DR_WIDTH-1:1]}.
  - A bit counter (width clog2(DR_WIDTH+1)) counts rise ticks. The fall tick after the DR_WIDTH-th rise exits to UPDATE.
- UPDATE (1 TCK period): jtag_update=1, jtag_state_udr=1, jtag_shift=0, jtag_state_sdr=0.
- RTI (1 TCK period): jtag_rti=1.
- RTI -> DONE:
  - jtag_ena drops to 0 and jtag_ir_in is held.
  - rsp_data <= sreg and rsp_valid=1.
- jtag_ena stays 1 throughout SETUP..RTI.
- DONE:
  - rsp_valid and rsp_data hold stable until rsp_ready.
  - On the rsp_valid && rsp_ready edge: rsp_valid=0, busy=0, go to IDLE.
  - cmd_ready rises the cycle after the handshake. No back-to-back accept in the handshake cycle.
- Latency: command accepted at edge 0 gives rsp_valid at edge 1 + 2*TCK_DIV*(DR_WIDTH+3).
  - DR_WIDTH=38, TCK_DIV=1: edge 83.
- Abort:
  - In any state other than IDLE/DONE, abort forces IDLE on the next edge.
  - Clears ena, shift, sdr, update, udr, rti and tck, and clears busy.
  - No response is produced; rsp_data is unchanged.
  - abort is ignored in IDLE/DONE.
- Simultaneous events:
  - abort with a rise tick: abort wins and no bit is captured.
  - reset with anything: reset wins.
- Wrap-around: the bit counter never exceeds DR_WIDTH and clears on SETUP entry.

Test Plan:
- Loopback: jtag_tdo tied to jtag_tdi, DR_WIDTH=38, TCK_DIV=1, cmd_ir=2'b01, cmd_data=38'h2A_5A5A_A5A5 -> rsp_data=38'h2A_5A5A_A5A5, rsp_valid at edge 83, exactly 38 jtag_shift TCK periods, jtag_ir_in=2'b01 throughout.
- Constant tdo=1, cmd_data=0, TCK_DIV=2 -> rsp_data=38'h3F_FFFF_FFFF, rsp_valid at edge 165, jtag_tck period 4 clk, 1 update pulse, 1 rti period.
- Back-pressure: rsp_ready held low for 10 cycles after rsp_valid -> rsp_valid/rsp_data stable, cmd_ready=0, second cmd_valid ignored; rsp_ready=1 -> cmd_ready=1 next cycle.
- cmd_valid pulses during SHIFT with different data -> ignored, first command's result returned unchanged.
- Abort on the 10th rise tick of SHIFT -> next edge all jtag_* outputs 0, busy=0, no rsp_valid, cmd_ready=1; a following command completes normally.
- Async reset asserted mid-SHIFT (between clk edges) -> outputs 0 immediately; after release, a new loopback command returns its own data.
